// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage:
// ALU operation codes, FSM state encoding and default widths.
package exec_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_REG_ADDR_WIDTH = 5;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_LSL   = 4'b1000;
   localparam logic [3:0] ALU_LSR   = 4'b1001;
   localparam logic [3:0] ALU_MUL   = 4'b1010;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/execute_stage_shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle,
// fixed iteration count, combinational done on the last iteration.
module shift_add_multiplier #(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] product,
   output logic                  done
);

   localparam int CW = $clog2(MUL_CYCLES);

   logic [DATA_WIDTH-1:0] multiplicand;
   logic [DATA_WIDTH-1:0] multiplier;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [CW-1:0]         count;
   logic                  active;
   logic                  last;

   assign acc_next = acc + (multiplier[0] ? multiplicand : '0);
   assign last     = count == CW'(MUL_CYCLES - 1);
   assign done     = active && last;
   assign product  = acc_next;

   // Load operands on start, then one shift-add step per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         multiplicand <= '0;
         multiplier   <= '0;
         acc          <= '0;
         count        <= '0;
         active       <= 1'b0;
      end else if (start) begin
         multiplicand <= a;
         multiplier   <= b;
         acc          <= '0;
         count        <= '0;
         active       <= 1'b1;
      end else if (active) begin
         acc          <= acc_next;
         multiplicand <= multiplicand << 1;
         multiplier   <= multiplier >> 1;
         count        <= count + CW'(1);
         if (last) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU plus iterative multiply feeding a registered
// EX/MEM slot, with valid/ready handshakes on both sides.
module execute_stage
   import exec_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
   parameter int MUL_CYCLES     = DEFAULT_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                alu_op,
   input  logic                      alu_src,
   input  logic [DATA_WIDTH-1:0]     read_data1,
   input  logic [DATA_WIDTH-1:0]     read_data2,
   input  logic [DATA_WIDTH-1:0]     immediate,
   input  logic [REG_ADDR_WIDTH-1:0] write_reg,
   input  logic                      reg_write_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     alu_result,
   output logic [DATA_WIDTH-1:0]     store_data,
   output logic                      zero,
   output logic [REG_ADDR_WIDTH-1:0] write_reg_out,
   output logic                      reg_write_out,
   output logic                      busy
);

   localparam int SHW = $clog2(DATA_WIDTH);

   state_t                    state;
   state_t                    state_next;
   logic [DATA_WIDTH-1:0]     operand_b;
   logic [DATA_WIDTH-1:0]     alu_value;
   logic [DATA_WIDTH-1:0]     mul_product;
   logic                      mul_done;
   logic                      accept;
   logic                      is_mul;
   logic                      start_mul;
   logic                      transfer;
   logic [REG_ADDR_WIDTH-1:0] mul_write_reg;
   logic                      mul_reg_write;
   logic [DATA_WIDTH-1:0]     mul_store_data;

   assign operand_b = alu_src ? immediate : read_data2;
   assign is_mul    = alu_op == ALU_MUL;
   assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign start_mul = accept && is_mul;
   assign transfer  = out_valid && out_ready;
   assign busy      = state == MUL;

   // Single-cycle ALU; MUL and unknown codes yield zero here
   always_comb begin
      alu_value = '0;
      case (alu_op)
         ALU_AND:   alu_value = read_data1 & operand_b;
         ALU_ORR:   alu_value = read_data1 | operand_b;
         ALU_ADD:   alu_value = read_data1 + operand_b;
         ALU_SUB:   alu_value = read_data1 - operand_b;
         ALU_PASSB: alu_value = operand_b;
         ALU_LSL:   alu_value = read_data1 << operand_b[SHW-1:0];
         ALU_LSR:   alu_value = read_data1 >> operand_b[SHW-1:0];
         default:   alu_value = '0;
      endcase
   end

   shift_add_multiplier #(
      .DATA_WIDTH (DATA_WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (start_mul),
      .a       (read_data1),
      .b       (operand_b),
      .product (mul_product),
      .done    (mul_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: enter MUL on a multiply accept, leave when done
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start_mul) state_next = MUL;
         MUL:  if (mul_done)  state_next = IDLE;
      endcase
   end

   // Hold multiply sidebands for the duration of the iteration
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_write_reg  <= '0;
         mul_reg_write  <= 1'b0;
         mul_store_data <= '0;
      end else if (start_mul) begin
         mul_write_reg  <= write_reg;
         mul_reg_write  <= reg_write_in;
         mul_store_data <= read_data2;
      end
   end

   // EX/MEM output slot: load on ALU accept or multiply completion
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid     <= 1'b0;
         alu_result    <= '0;
         store_data    <= '0;
         zero          <= 1'b0;
         write_reg_out <= '0;
         reg_write_out <= 1'b0;
      end else if (accept && !is_mul) begin
         out_valid     <= 1'b1;
         alu_result    <= alu_value;
         zero          <= alu_value == '0;
         store_data    <= read_data2;
         write_reg_out <= write_reg;
         reg_write_out <= reg_write_in;
      end else if (mul_done) begin
         out_valid     <= 1'b1;
         alu_result    <= mul_product;
         zero          <= mul_product == '0;
         store_data    <= mul_store_data;
         write_reg_out <= mul_write_reg;
         reg_write_out <= mul_reg_write;
      end else if (transfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic        alu_src;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [31:0] immediate;
   logic [4:0]  write_reg;
   logic        reg_write_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        zero;
   logic [4:0]  write_reg_out;
   logic        reg_write_out;
   logic        busy;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [3:0]  op;
      logic        src;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  wr;
      logic        rw;
   } vec_t;

   execute_stage dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_op        (alu_op),
      .alu_src       (alu_src),
      .read_data1    (read_data1),
      .read_data2    (read_data2),
      .immediate     (immediate),
      .write_reg     (write_reg),
      .reg_write_in  (reg_write_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .alu_result    (alu_result),
      .store_data    (store_data),
      .zero          (zero),
      .write_reg_out (write_reg_out),
      .reg_write_out (reg_write_out),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input vec_t v);
      logic [31:0] b;
      longint unsigned p;
      b = v.src ? v.imm : v.b;
      case (v.op)
         4'b0000: return v.a & b;
         4'b0001: return v.a | b;
         4'b0010: return v.a + b;
         4'b0110: return v.a - b;
         4'b0111: return b;
         4'b1000: return v.a << b[4:0];
         4'b1001: return v.a >> b[4:0];
         4'b1010: begin
            p = longint'(v.a) * longint'(b);
            return p[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive_op(input vec_t v);
      in_valid     = 1'b1;
      alu_op       = v.op;
      alu_src      = v.src;
      read_data1   = v.a;
      read_data2   = v.b;
      immediate    = v.imm;
      write_reg    = v.wr;
      reg_write_in = v.rw;
   endtask

   task automatic test_reset();
      in_valid = 0; alu_op = 0; alu_src = 0;
      read_data1 = 0; read_data2 = 0; immediate = 0;
      write_reg = 0; reg_write_in = 0; out_ready = 1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: got v=%b r=%b b=%b want 0 1 0",
                  out_valid, in_ready, busy);
      end
      total++;
      if (alu_result !== 32'd0 || store_data !== 32'd0 || zero !== 1'b0 ||
          write_reg_out !== 5'd0 || reg_write_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_data: got res=%h sd=%h z=%b wr=%0d rw=%b want 0",
                  alu_result, store_data, zero, write_reg_out, reg_write_out);
      end
   endtask

   task automatic test_alu_directed();
      vec_t q[$];
      logic [31:0] exp;
      q.push_back('{4'b0010, 1'b1, 32'd5, 32'd99, 32'd7, 5'd3, 1'b1});
      q.push_back('{4'b0110, 1'b0, 32'd9, 32'd9, 32'd0, 5'd4, 1'b1});
      q.push_back('{4'b0110, 1'b0, 32'd0, 32'd1, 32'd0, 5'd5, 1'b0});
      q.push_back('{4'b1001, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 5'd6, 1'b1});
      q.push_back('{4'b1000, 1'b1, 32'h0000_0003, 32'h1234, 32'd30, 5'd7, 1'b1});
      q.push_back('{4'b0000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd8, 1'b1});
      q.push_back('{4'b0001, 1'b1, 32'hF000_0000, 32'd0, 32'h0000_000F, 5'd9, 1'b1});
      q.push_back('{4'b0111, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h7777_0000, 5'd10, 1'b1});
      q.push_back('{4'b0011, 1'b0, 32'd123, 32'd456, 32'd0, 5'd11, 1'b1});
      q.push_back('{4'b1111, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 5'd12, 1'b0});
      out_ready = 1'b1;
      foreach (q[i]) begin
         drive_op(q[i]);
         exp = ref_alu(q[i]);
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || alu_result !== exp ||
             zero !== (exp == 32'd0)) begin
            bad++;
            $display("FAIL alu_%0d: got v=%b res=%h z=%b want 1 %h %b",
                     i, out_valid, alu_result, zero, exp, exp == 32'd0);
         end
         total++;
         if (write_reg_out !== q[i].wr || reg_write_out !== q[i].rw ||
             store_data !== q[i].b) begin
            bad++;
            $display("FAIL side_%0d: got wr=%0d rw=%b sd=%h want %0d %b %h",
                     i, write_reg_out, reg_write_out, store_data,
                     q[i].wr, q[i].rw, q[i].b);
         end
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic run_mul(input vec_t v, input string name);
      logic [31:0] exp;
      exp = ref_alu(v);
      out_ready = 1'b1;
      drive_op(v);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         total++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy c=%0d: got b=%b r=%b v=%b want 1 0 0",
                     name, c, busy, in_ready, out_valid);
         end
         @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b1 || alu_result !== exp || busy !== 1'b0 ||
          write_reg_out !== v.wr || zero !== (exp == 32'd0)) begin
         bad++;
         $display("FAIL %s_done: got v=%b res=%h b=%b wr=%0d want 1 %h 0 %0d",
                  name, out_valid, alu_result, busy, write_reg_out, exp, v.wr);
      end
      @(negedge clk);
   endtask

   task automatic test_mul();
      run_mul('{4'b1010, 1'b0, 32'h0001_0003, 32'd5, 32'd0, 5'd13, 1'b1},
              "mul_a");
      run_mul('{4'b1010, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 5'd14, 1'b1},
              "mul_b");
   endtask

   task automatic test_backpressure();
      vec_t v1;
      vec_t v2;
      logic [31:0] e1;
      logic [31:0] e2;
      v1 = '{4'b0010, 1'b0, 32'd100, 32'd23, 32'd0, 5'd15, 1'b1};
      v2 = '{4'b0110, 1'b1, 32'd50, 32'hAAAA, 32'd8, 5'd16, 1'b0};
      e1 = ref_alu(v1);
      e2 = ref_alu(v2);
      out_ready = 1'b0;
      drive_op(v1);
      @(negedge clk);
      drive_op(v2);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== e1 ||
             write_reg_out !== v1.wr || store_data !== v1.b) begin
            bad++;
            $display("FAIL stall_%0d: got v=%b r=%b res=%h wr=%0d want 1 0 %h %0d",
                     c, out_valid, in_ready, alu_result, write_reg_out, e1, v1.wr);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || alu_result !== e2 || write_reg_out !== v2.wr ||
          reg_write_out !== v2.rw) begin
         bad++;
         $display("FAIL replace: got v=%b res=%h wr=%0d rw=%b want 1 %h %0d %b",
                  out_valid, alu_result, write_reg_out, reg_write_out,
                  e2, v2.wr, v2.rw);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL replace_drain: got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit rose;
      out_ready = 1'b1;
      drive_op('{4'b1010, 1'b0, 32'd7, 32'd9, 32'd0, 5'd17, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort: got b=%b r=%b v=%b want 0 1 0",
                  busy, in_ready, out_valid);
      end
      rose = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) rose = 1;
      end
      total++;
      if (rose) begin
         bad++;
         $display("FAIL abort_valid: got out_valid rising want none");
      end
   endtask

   task automatic test_random();
      logic [3:0] ops[10];
      vec_t v;
      logic [31:0] exp;
      int cnt;
      int stall;
      int want_lat;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
              4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1110};
      for (int n = 0; n < 40; n++) begin
         v.op  = ops[$urandom_range(9)];
         v.src = 1'($urandom_range(1));
         v.a   = $urandom;
         v.b   = $urandom;
         v.imm = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
         v.wr  = 5'($urandom_range(31));
         v.rw  = 1'($urandom_range(1));
         exp = ref_alu(v);
         want_lat = (v.op == 4'b1010) ? 33 : 1;
         out_ready = 1'b1;
         drive_op(v);
         @(negedge clk);
         in_valid = 1'b0;
         cnt = 1;
         while (out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
         end
         total++;
         if (out_valid !== 1'b1 || cnt != want_lat) begin
            bad++;
            $display("FAIL rnd_lat_%0d: got v=%b lat=%0d want 1 %0d",
                     n, out_valid, cnt, want_lat);
         end
         stall = $urandom_range(2);
         out_ready = (stall == 0);
         for (int s = 0; s <= stall; s++) begin
            total++;
            if (alu_result !== exp || zero !== (exp == 32'd0) ||
                write_reg_out !== v.wr || reg_write_out !== v.rw ||
                store_data !== v.b) begin
               bad++;
               $display("FAIL rnd_%0d op=%b: got res=%h z=%b wr=%0d want %h %b %0d",
                        n, v.op, alu_result, zero, write_reg_out,
                        exp, exp == 32'd0, v.wr);
            end
            if (s < stall) begin
               if (s == stall - 1) out_ready = 1'b1;
               @(negedge clk);
            end
         end
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rnd_drain_%0d: got %b want 0", n, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
